// File: rtl/hybrid_pwm_sd_mc.sv
// Multi-channel hybrid PWM / sigma-delta DAC.
// Each channel turns a DW-bit sample into a 1-bit output. A P-bit PWM frame
// carries the coarse value. A first-order error accumulator carries the
// remaining fine bits from frame to frame. An optional periodic dump re-centres
// every residual so that idle tones cannot lock in.
module hybrid_pwm_sd_mc #(
  parameter int CHANNELS  = 2,
  parameter int DW        = 16,
  parameter int PWM_BITS  = 5,
  parameter int DUMP_BITS = 10,
  parameter int SIGNED_IN = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CHANNELS*DW-1:0] din,
  input  logic                   din_valid,
  output logic                   sample_req,
  output logic [CHANNELS-1:0]    q
);

  localparam int P  = PWM_BITS;
  localparam int RW = DW - PWM_BITS;

  localparam logic [P-1:0]  CNT_MAX    = {P{1'b1}};
  localparam logic [P-1:0]  CNT_PRE    = CNT_MAX - P'(1);
  localparam logic [P-1:0]  THR_MID    = P'(1) << (P - 1);
  localparam logic [DW-1:0] MID_CODE   = DW'(1) << (DW - 1);
  localparam logic [DW-1:0] SCALE_BASE = DW'(1) << RW;
  localparam logic [RW-1:0] RES_DUMP   = RW'(1) << (RW - 1);

  // The hold register resets to whichever raw code decodes to unsigned midscale.
  localparam logic [DW-1:0] HOLD_RESET = (SIGNED_IN != 0) ? '0 : MID_CODE;

  logic [P-1:0] cnt;
  logic         frame_end;
  logic         dump;

  assign frame_end = (cnt == CNT_MAX);

  // Free-running frame counter shared by all channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + P'(1);
    end
  end

  // Request the next sample during the last clock of every frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_req <= 1'b0;
    end else begin
      sample_req <= (cnt == CNT_PRE);
    end
  end

  if (DUMP_BITS > 0) begin : g_dump
    logic [DUMP_BITS-1:0] dump_cnt;
    logic                 dump_r;

    // Dump timer: the strobe is high for the one clock that follows each wrap.
    always_ff @(posedge clk) begin
      if (reset) begin
        dump_cnt <= '0;
        dump_r   <= 1'b0;
      end else begin
        dump_cnt <= dump_cnt + DUMP_BITS'(1);
        dump_r   <= (dump_cnt == {DUMP_BITS{1'b1}});
      end
    end

    assign dump = dump_r;
  end else begin : g_no_dump
    assign dump = 1'b0;
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [DW-1:0] hold;
    logic [DW-1:0] u;
    logic [DW-1:0] ceil_part;
    logic [DW-1:0] f_val;
    logic [DW-1:0] scaled;
    logic [DW-1:0] sigma;
    logic [DW-1:0] sum;
    logic [P-1:0]  thr;
    logic          q_bit;

    // The signed format differs from offset binary only in the sign bit.
    assign u = (SIGNED_IN != 0) ? {~hold[DW-1], hold[DW-2:0]} : hold;

    // floor(u*(2^P-2)/2^P) equals u - ceil(u/2^(P-1)). This exact form needs no wide product.
    assign ceil_part = {{(P - 1){1'b0}}, u[DW-1:P-1]} + DW'(|u[P-2:0]);
    assign f_val     = SCALE_BASE + u - ceil_part;

    // The residual field feeds back into the next frame's total.
    assign sum = scaled + {{P{1'b0}}, sigma[RW-1:0]};

    // Hold the most recent sample until a new one is presented.
    always_ff @(posedge clk) begin
      if (reset) begin
        hold <= HOLD_RESET;
      end else if (din_valid) begin
        hold <= din[n*DW +: DW];
      end
    end

    // Three-stage frame pipeline: scale, accumulate, and latch the PWM threshold.
    always_ff @(posedge clk) begin
      if (reset) begin
        scaled <= MID_CODE;
        sigma  <= MID_CODE;
        thr    <= THR_MID;
      end else begin
        if (frame_end) begin
          scaled          <= f_val;
          sigma[DW-1:RW]  <= sum[DW-1:RW];
          thr             <= sigma[DW-1:RW];
        end
        if (dump) begin
          sigma[RW-1:0] <= RES_DUMP;
        end else if (frame_end) begin
          sigma[RW-1:0] <= sum[RW-1:0];
        end
      end
    end

    // Registered PWM compare. Output is high while the count is at or below the threshold.
    always_ff @(posedge clk) begin
      if (reset) begin
        q_bit <= 1'b0;
      end else begin
        q_bit <= enable && (cnt <= thr);
      end
    end

    assign q[n] = q_bit;
  end

endmodule

// File: tb/tb_hybrid_pwm_sd_mc.sv
// Self-checking bench for hybrid_pwm_sd_mc. Two instances share the stimulus.
// Instance A uses offset-binary input with dumping enabled.
// Instance B uses two's-complement input with dumping disabled.
module tb_hybrid_pwm_sd_mc;

  localparam int CH          = 2;
  localparam int DW          = 16;
  localparam int P           = 5;
  localparam int FRAME       = 1 << P;
  localparam int RES_SPAN    = 1 << (DW - P);
  localparam int MID         = 1 << (DW - 1);
  localparam int DUMP_PERIOD = 1 << 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [CH*DW-1:0] din;
  logic             din_valid;
  logic             sample_req_a;
  logic             sample_req_b;
  logic [CH-1:0]    q_a;
  logic [CH-1:0]    q_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hybrid_pwm_sd_mc #(
    .CHANNELS(CH), .DW(DW), .PWM_BITS(P), .DUMP_BITS(10), .SIGNED_IN(0)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .din(din),
    .din_valid(din_valid), .sample_req(sample_req_a), .q(q_a)
  );

  hybrid_pwm_sd_mc #(
    .CHANNELS(CH), .DW(DW), .PWM_BITS(P), .DUMP_BITS(0), .SIGNED_IN(1)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .din(din),
    .din_valid(din_valid), .sample_req(sample_req_b), .q(q_b)
  );

  // Reference model state. tm is the number of clocks since reset. The PWM
  // level of each frame is the integer quotient of the running total.
  int tm = 0;
  int phase;
  int total;
  int m_hold[2][CH];
  int m_scaled[2][CH];
  int m_sigma[2][CH];
  int m_thr[2][CH];
  bit exp_q[2][CH];
  bit exp_req = 1'b0;
  bit model_ready = 1'b0;

  function automatic int to_unsigned(input int inst, input int code);
    return (inst == 1) ? (code ^ MID) : code;
  endfunction

  function automatic int scale_of(input int u);
    return RES_SPAN + (u * (FRAME - 2)) / FRAME;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the behavioural model by one clock using the inputs the DUT sees.
  always @(posedge clk) begin
    if (reset) begin
      tm = 0;
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < CH; c++) begin
          m_hold[i][c]   = to_unsigned(i, MID);
          m_scaled[i][c] = MID;
          m_sigma[i][c]  = MID;
          m_thr[i][c]    = FRAME / 2;
          exp_q[i][c]    = 1'b0;
        end
      end
      exp_req     = 1'b0;
      model_ready = 1'b1;
    end else begin
      phase   = tm % FRAME;
      exp_req = (((tm + 1) % FRAME) == FRAME - 1);
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < CH; c++) begin
          exp_q[i][c] = (enable === 1'b1) && (phase <= m_thr[i][c]);
          if (phase == FRAME - 1) begin
            total          = m_scaled[i][c] + (m_sigma[i][c] % RES_SPAN);
            m_thr[i][c]    = m_sigma[i][c] / RES_SPAN;
            m_scaled[i][c] = scale_of(to_unsigned(i, m_hold[i][c]));
            m_sigma[i][c]  = total;
          end
          if (i == 0 && tm > 0 && (tm % DUMP_PERIOD) == 0) begin
            m_sigma[i][c] = (m_sigma[i][c] / RES_SPAN) * RES_SPAN + RES_SPAN / 2;
          end
          if (din_valid === 1'b1) begin
            m_hold[i][c] = int'(din[c*DW +: DW]);
          end
        end
      end
      tm++;
    end
  end

  // Compare every output against the model on every falling edge.
  always @(negedge clk) begin
    if (model_ready) begin
      for (int c = 0; c < CH; c++) begin
        check_output($sformatf("q_a[%0d]", c), 32'(q_a[c]), 32'(exp_q[0][c]));
        check_output($sformatf("q_b[%0d]", c), 32'(q_b[c]), 32'(exp_q[1][c]));
      end
      check_output("sample_req_a", 32'(sample_req_a), 32'(exp_req));
      check_output("sample_req_b", 32'(sample_req_b), 32'(exp_req));
    end
  end

  task automatic apply_stimulus(input logic [DW-1:0] ch0, input logic [DW-1:0] ch1);
    din       = {ch1, ch0};
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int guard;
    guard = 0;
    while ((tm % FRAME) != ph && guard < 3 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    check_output("frame_align", 32'(tm % FRAME), 32'(ph));
  endtask

  // Count high clocks of one output frame. q lags cnt by one clock, so an
  // output frame starts on the falling edge where tm % FRAME == 1.
  task automatic measure_frame(output int a0, output int a1, output int b0,
                               output int b1, output int req);
    a0 = 0; a1 = 0; b0 = 0; b1 = 0; req = 0;
    for (int k = 0; k < FRAME; k++) begin
      a0  += int'(q_a[0]);
      a1  += int'(q_a[1]);
      b0  += int'(q_b[0]);
      b1  += int'(q_b[1]);
      req += int'(sample_req_a);
      @(negedge clk);
    end
  endtask

  initial begin
    int a0, a1, b0, b1, req, bad, n;
    reset     = 1'b1;
    enable    = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    repeat (3) @(negedge clk);
    check_output("reset_q_a", 32'(q_a), 0);
    check_output("reset_req_a", 32'(sample_req_a), 0);
    reset = 1'b0;

    // Midscale right after reset: 17 of every 32 clocks high from the first frame.
    wait_phase(1);
    for (int f = 0; f < 2; f++) begin
      measure_frame(a0, a1, b0, b1, req);
      check_output("mid_a0", a0, 17);
      check_output("mid_a1", a1, 17);
      check_output("mid_b0", b0, 17);
      check_output("mid_b1", b1, 17);
      check_output("mid_req", req, 1);
    end

    // Full-scale extremes.
    apply_stimulus(16'h0000, 16'hFFFF);
    wait_phase(1);
    repeat (2) measure_frame(a0, a1, b0, b1, req);
    for (int f = 0; f < 2; f++) begin
      measure_frame(a0, a1, b0, b1, req);
      check_output("zero_a0", a0, 2);
      checks++;
      if (a1 != 31 && a1 != 32) begin
        errors++;
        $display("[TB] FAIL full_a1: actual=%0d required=31 or 32", a1);
      end
      check_output("signed_zero_b0", b0, 17);
    end

    // Signed input mapping.
    apply_stimulus(16'h8000, 16'h0000);
    wait_phase(1);
    repeat (2) measure_frame(a0, a1, b0, b1, req);
    measure_frame(a0, a1, b0, b1, req);
    check_output("off_mid_a0", a0, 17);
    check_output("off_zero_a1", a1, 2);
    check_output("signed_min_b0", b0, 2);
    check_output("signed_zero_b1", b1, 17);

    // Latency: the sample changes one clock before a frame end.
    wait_phase(FRAME - 2);
    apply_stimulus(16'h0000, 16'h0000);
    wait_phase(1);
    measure_frame(a0, a1, b0, b1, req);
    check_output("lat1_a0", a0, 17);
    check_output("lat1_b0", b0, 2);
    measure_frame(a0, a1, b0, b1, req);
    check_output("lat2_a0", a0, 17);
    check_output("lat2_b0", b0, 2);
    measure_frame(a0, a1, b0, b1, req);
    check_output("lat3_a0", a0, 2);
    check_output("lat3_b0", b0, 17);

    // Enable low for 40 clocks in mid-frame.
    wait_phase(10);
    enable = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (q_a !== '0 || q_b !== '0) bad++;
    end
    check_output("enable_low_q", bad, 0);
    enable = 1'b1;

    // Reset pulse when the count is 13.
    wait_phase(13);
    reset = 1'b1;
    @(negedge clk);
    check_output("midreset_q_a", 32'(q_a), 0);
    check_output("midreset_q_b", 32'(q_b), 0);
    reset = 1'b0;
    n = 0;
    while (sample_req_a !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check_output("req_after_reset", n, FRAME - 1);
    wait_phase(1);
    measure_frame(a0, a1, b0, b1, req);
    check_output("postreset_a0", a0, 17);
    check_output("postreset_b1", b1, 17);

    // Random samples and enable changes across several dump periods.
    for (int k = 0; k < 6000; k++) begin
      din       = $urandom;
      din_valid = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      @(negedge clk);
    end
    din_valid = 1'b0;
    enable    = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

endmodule
